// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control FSM for the 16-bit CPU datapath. Each instruction walks
//   through fetch, decode, execute, memory and write-back states. Memory is
//   reached through a request/ready handshake. The FSM counts retired
//   instructions and halts on an illegal opcode or on a memory timeout.
//
//   Memory handshake: mem_req is a request, and mem_ready completes it.
//   mem_req stays high, with mem_we stable, until the first cycle in which
//   mem_ready=1. That cycle completes the transfer. mem_ready is ignored
//   whenever mem_req=0.
//
// Parameters
//   CNT_W     width of instr_cnt
//   WAIT_MAX  maximum wait cycles per memory request (0 = never time out)
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   opcode       instruction [15:12]; used in DECODE, ADDR and BRANCH
//   zero         ALU zero flag; used in BRANCH
//   mem_ready    memory done
//   mem_req      memory request
//   mem_we       1=write, 0=read
//   ir_write     load the IR
//   pc_write     load the PC
//   pc_src       00=PC+2, 01=branch target, 10=jump target
//   alu_src      1=sign-extended immediate, 0=register
//   alu_op       00=add, 01=sub, 10=function from opcode
//   reg_write    register-file write enable
//   reg_dst      1=rd, 0=rt
//   mem_to_reg   1=memory data, 0=ALU result
//   halted       FSM is in HALT
//   timeout      sticky: the halt was caused by a memory timeout
//   instr_cnt    retired-instruction count (wraps)
//   state_dbg    current state encoding
module multicycle_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_MEM = 4'd6,
    S_EXEC   = 4'd7,
    S_WB_ALU = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [3:0] OP_LW  = 4'b0000;
  localparam logic [3:0] OP_SW  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  // The counter value during the WAIT_MAX-th wait cycle of one request.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                mem_wait;
  logic                wait_expired;
  logic                retire;
  logic                is_rtype;
  logic                taken;

  assign is_rtype = (opcode >= 4'd2) && (opcode <= 4'd9);
  assign taken    = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

  assign state_dbg = state;

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    retire     = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        // IR and PC load only in the cycle in which the fetch completes.
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) next_state = S_ADDR;
        else if (is_rtype)                      next_state = S_EXEC;
        else if (opcode == OP_BEQ || opcode == OP_BNE) next_state = S_BRANCH;
        else if (opcode == OP_JMP)              next_state = S_JUMP;
        else                                    next_state = S_HALT;
      end
      S_ADDR: begin
        alu_src    = 1'b1;
        next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) next_state = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_EXEC: begin
        alu_op     = 2'b10;
        next_state = S_WB_ALU;
      end
      S_WB_ALU: begin
        alu_op     = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_op = 2'b01;
        if (taken) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: next_state = S_IDLE;
    endcase

    // A wait cycle is a pending request without ready. If ready arrives in the
    // cycle the limit would be reached, it is not a wait cycle, so the
    // transfer completes normally.
    mem_wait     = mem_req && !mem_ready;
    wait_expired = (WAIT_MAX != 0) && mem_wait && (wait_cnt == WAIT_LAST);
    if (wait_expired) begin
      next_state = S_HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      instr_cnt <= '0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= next_state;
      if (retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
      if (wait_expired) begin
        timeout <= 1'b1;
      end
      // Every memory state is entered from a different state, so a state
      // change is enough to restart the count for each new request.
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (mem_wait) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl (CNT_W=4, WAIT_MAX=4). For each cycle,
//   the driver applies the inputs and pushes the expected state, controls and
//   count. A monitor on the falling edge pops each expectation and compares it
//   with the DUT outputs.
module tb_multicycle_ctrl;

  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 4;
  localparam int W        = 4 + 14 + CNT_W;

  logic             clk;
  logic             rst;
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       state_dbg;

  multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted), .timeout(timeout),
    .instr_cnt(instr_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
    S_ADDR = 4'd3, S_MEM_RD = 4'd4, S_MEM_WR = 4'd5, S_WB_MEM = 4'd6,
    S_EXEC = 4'd7, S_WB_ALU = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_HALT = 4'd11;

  localparam logic [3:0] OP_LW = 4'b0000, OP_SW = 4'b0001, OP_ADD = 4'b0010,
    OP_SUB = 4'b0011, OP_SLT = 4'b1001, OP_BEQ = 4'b1011, OP_BNE = 4'b1100,
    OP_JMP = 4'b1101;

  // Control bits in this order:
  // {mem_req,mem_we, ir_write,pc_write, pc_src, alu_src, alu_op,
  //  reg_write,reg_dst,mem_to_reg, halted,timeout}
  localparam logic [13:0] C_NONE    = 14'b00_00_00_0_00_000_00;
  localparam logic [13:0] C_REQ     = 14'b10_00_00_0_00_000_00;
  localparam logic [13:0] C_FGO     = 14'b10_11_00_0_00_000_00;
  localparam logic [13:0] C_ADDR    = 14'b00_00_00_1_00_000_00;
  localparam logic [13:0] C_MEMWR   = 14'b11_00_00_0_00_000_00;
  localparam logic [13:0] C_WBMEM   = 14'b00_00_00_0_00_101_00;
  localparam logic [13:0] C_EXEC    = 14'b00_00_00_0_10_000_00;
  localparam logic [13:0] C_WBALU   = 14'b00_00_00_0_10_110_00;
  localparam logic [13:0] C_BR_NT   = 14'b00_00_00_0_01_000_00;
  localparam logic [13:0] C_BR_T    = 14'b00_01_01_0_01_000_00;
  localparam logic [13:0] C_JMP     = 14'b00_01_10_0_00_000_00;
  localparam logic [13:0] C_HALT    = 14'b00_00_00_0_00_000_10;
  localparam logic [13:0] C_HALT_TO = 14'b00_00_00_0_00_000_11;

  // scoreboard
  logic [W-1:0]     exp_q[$];
  string            tag_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  wire [W-1:0] obs = {state_dbg, mem_req, mem_we, ir_write, pc_write, pc_src,
                      alu_src, alu_op, reg_write, reg_dst, mem_to_reg, halted,
                      timeout, instr_cnt};

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL %s @%0t: got st=%0d ctl=%b cnt=%0d, want st=%0d ctl=%b cnt=%0d",
                 t, $time, obs[W-1 -: 4], obs[W-5 -: 14], obs[CNT_W-1:0],
                 e[W-1 -: 4], e[W-5 -: 14], e[CNT_W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic cyc(input string tag, input logic [3:0] op, input logic z,
                     input logic rdy, input logic [3:0] st, input logic [13:0] ctl);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back({st, ctl, exp_cnt});
    tag_q.push_back(tag);
  endtask

  // Asserts reset 1 time unit after an edge; the sample in the same cycle
  // shows that the reset took effect without waiting for a clock edge.
  task automatic rst_cyc(input string tag);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_ready = 1'b0;
    exp_cnt   = '0;
    exp_q.push_back({S_IDLE, C_NONE, exp_cnt});
    tag_q.push_back(tag);
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    cyc(tag, op, 1'b0, 1'b1, S_FETCH, C_FGO);
    cyc(tag, op, 1'b0, 1'b1, S_DECODE, C_NONE);
  endtask

  task automatic rtype(input string tag, input logic [3:0] op);
    fetch(tag, op);
    cyc(tag, op, 1'b0, 1'b1, S_EXEC, C_EXEC);
    cyc(tag, op, 1'b0, 1'b1, S_WB_ALU, C_WBALU);
    exp_cnt++;
  endtask

  task automatic branch(input string tag, input logic [3:0] op, input logic z,
                        input logic [13:0] ctl);
    fetch(tag, op);
    cyc(tag, op, z, 1'b1, S_BRANCH, ctl);
    exp_cnt++;
  endtask

  task automatic jmp(input string tag);
    fetch(tag, OP_JMP);
    cyc(tag, OP_JMP, 1'b0, 1'b1, S_JUMP, C_JMP);
    exp_cnt++;
  endtask

  initial begin
    rst = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0; exp_cnt = '0;

    rst_cyc("reset");
    cyc("t1_idle", OP_ADD, 1'b0, 1'b1, S_IDLE, C_NONE);
    rtype("t1_add", OP_ADD);

    // LW: 3 wait cycles in FETCH, 2 in MEM_RD
    repeat (3) cyc("t2_fetch_wait", OP_LW, 1'b0, 1'b0, S_FETCH, C_REQ);
    fetch("t2_lw", OP_LW);
    cyc("t2_addr", OP_LW, 1'b0, 1'b1, S_ADDR, C_ADDR);
    repeat (2) cyc("t2_rd_wait", OP_LW, 1'b0, 1'b0, S_MEM_RD, C_REQ);
    cyc("t2_rd_done", OP_LW, 1'b0, 1'b1, S_MEM_RD, C_REQ);
    cyc("t2_wb_mem", OP_LW, 1'b0, 1'b1, S_WB_MEM, C_WBMEM);
    exp_cnt++;

    fetch("sw", OP_SW);
    cyc("sw_addr", OP_SW, 1'b0, 1'b1, S_ADDR, C_ADDR);
    cyc("sw_wr", OP_SW, 1'b0, 1'b1, S_MEM_WR, C_MEMWR);
    exp_cnt++;

    rtype("slt", OP_SLT);
    rtype("sub", OP_SUB);

    branch("t3_beq_z1", OP_BEQ, 1'b1, C_BR_T);
    branch("t3_beq_z0", OP_BEQ, 1'b0, C_BR_NT);
    branch("t3_bne_z0", OP_BNE, 1'b0, C_BR_T);
    branch("t3_bne_z1", OP_BNE, 1'b1, C_BR_NT);
    jmp("jmp");

    // count wrap: 16 jumps from reset bring a 4-bit count back to 0
    rst_cyc("t6_reset");
    cyc("t6_idle", OP_JMP, 1'b0, 1'b1, S_IDLE, C_NONE);
    for (int i = 0; i < 16; i++) jmp("t6_jmp");
    exp_cnt = 4'd0;
    jmp("t6_after_wrap");

    // ready arrives on the 4th cycle: the store completes
    fetch("rdy_wins", OP_SW);
    cyc("rdy_wins_addr", OP_SW, 1'b0, 1'b1, S_ADDR, C_ADDR);
    repeat (3) cyc("rdy_wins_wait", OP_SW, 1'b0, 1'b0, S_MEM_WR, C_MEMWR);
    cyc("rdy_wins_done", OP_SW, 1'b0, 1'b1, S_MEM_WR, C_MEMWR);
    exp_cnt++;
    jmp("rdy_wins_next");

    // timeout: SW never acknowledged
    fetch("t5_sw", OP_SW);
    cyc("t5_addr", OP_SW, 1'b0, 1'b1, S_ADDR, C_ADDR);
    repeat (4) cyc("t5_wait", OP_SW, 1'b0, 1'b0, S_MEM_WR, C_MEMWR);
    repeat (3) cyc("t5_halt", OP_SW, 1'b0, 1'b0, S_HALT, C_HALT_TO);
    cyc("t5_halt_rdy", OP_SW, 1'b0, 1'b1, S_HALT, C_HALT_TO);

    rst_cyc("t5_reset");
    cyc("t5_idle", OP_ADD, 1'b0, 1'b1, S_IDLE, C_NONE);

    // illegal opcode 1010
    fetch("t4_ill", 4'b1010);
    repeat (20) cyc("t4_halt", 4'b1010, 1'b0, 1'b1, S_HALT, C_HALT);
    rst_cyc("t4_reset");
    cyc("t4_idle", OP_ADD, 1'b0, 1'b1, S_IDLE, C_NONE);

    // illegal opcode 1111
    fetch("ill_f", 4'b1111);
    repeat (2) cyc("ill_f_halt", 4'b1111, 1'b0, 1'b1, S_HALT, C_HALT);
    rst_cyc("ill_f_reset");
    cyc("ill_f_idle", OP_JMP, 1'b0, 1'b1, S_IDLE, C_NONE);

    // reset in the middle of a store
    jmp("mid_jmp");
    fetch("mid_sw", OP_SW);
    cyc("mid_addr", OP_SW, 1'b0, 1'b1, S_ADDR, C_ADDR);
    cyc("mid_wr", OP_SW, 1'b0, 1'b0, S_MEM_WR, C_MEMWR);
    rst_cyc("t6_mid_reset");
    cyc("t6_mid_idle", OP_JMP, 1'b0, 1'b1, S_IDLE, C_NONE);
    jmp("t6_mid_jmp");

    // let the monitor drain the queue
    repeat (2) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
